// File: rtl/combination_lock_pkg.sv
// Shared encodings for the combination lock controller and the lock FSM it drives.
package combination_lock_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef enum logic [2:0] {
        ARMED    = 3'b000,
        PULSE    = 3'b001,
        EVAL     = 3'b010,
        LOCKOUT  = 3'b011,
        UNLOCKED = 3'b100
    } ctrl_state_e;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector; prev resets high so a level held through reset gives no rise.
module key_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic Level,
    output logic Rise
);

    logic r_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= Level;
        end
    end

    assign Rise = Level & ~r_prev;

endmodule

// File: rtl/combination_lock_controller.sv
// Sequences key strobes into the lock FSM, judges each step from its state,
// and enforces a timed lockout after repeated failures.
module combination_lock_controller
    import combination_lock_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Key1Raw,
    input  logic       Key2Raw,
    input  logic       Relock,
    input  logic [1:0] FsmState,
    output logic       Key1Pulse,
    output logic       Key2Pulse,
    output logic       FsmReset,
    output logic       Alarm,
    output logic       Unlocked,
    output logic [1:0] FailCount,
    output logic [2:0] state
);

    localparam logic [1:0]       MAX_FAILS_W = 2'(MAX_FAILS);
    localparam logic [CNT_W-1:0] TIMER_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);

    logic w_key1_rise, w_key2_rise, w_relock_rise;

    key_edge_detect u_key1_edge   (.Clk(Clk), .Reset(Reset), .Level(Key1Raw), .Rise(w_key1_rise));
    key_edge_detect u_key2_edge   (.Clk(Clk), .Reset(Reset), .Level(Key2Raw), .Rise(w_key2_rise));
    key_edge_detect u_relock_edge (.Clk(Clk), .Reset(Reset), .Level(Relock),  .Rise(w_relock_rise));

    ctrl_state_e      r_state, w_state_next;
    logic [1:0]       r_expected, w_expected_next;
    logic [CNT_W-1:0] r_timer, w_timer_next;
    logic [1:0]       r_fail_count, w_fail_next, w_fail_inc;
    logic             r_key1_pulse, r_key2_pulse, r_fsm_reset, r_alarm, r_unlocked;
    logic             w_key1_next, w_key2_next, w_relock_pulse, w_fail_take;

    assign w_fail_inc = (r_fail_count == MAX_FAILS_W) ? r_fail_count : r_fail_count + 2'd1;

    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_timer_next    = r_timer;
        w_fail_next     = r_fail_count;
        w_key1_next     = 1'b0;
        w_key2_next     = 1'b0;
        w_relock_pulse  = 1'b0;
        w_fail_take     = 1'b0;

        case (r_state)
            ARMED: begin
                if (w_key1_rise && w_key2_rise) begin
                    w_fail_take = 1'b1;
                end else if (w_key1_rise || w_key2_rise) begin
                    w_key1_next     = w_key1_rise;
                    w_key2_next     = w_key2_rise;
                    w_expected_next = FsmState + 2'd1;
                    w_state_next    = PULSE;
                end else if (FsmState == S3) begin
                    w_state_next = UNLOCKED;
                end
            end
            PULSE: w_state_next = EVAL;
            EVAL: begin
                if (FsmState == r_expected) begin
                    if (r_expected == S3) begin
                        w_fail_next  = 2'd0;
                        w_state_next = UNLOCKED;
                    end else begin
                        w_state_next = ARMED;
                    end
                end else begin
                    w_fail_take = 1'b1;
                end
            end
            LOCKOUT: begin
                if (r_timer == '0) begin
                    w_fail_next  = 2'd0;
                    w_state_next = ARMED;
                end else begin
                    w_timer_next = r_timer - TIMER_ONE;
                end
            end
            UNLOCKED: begin
                if (w_relock_rise) begin
                    w_relock_pulse = 1'b1;
                    w_state_next   = ARMED;
                end
            end
            default: w_state_next = ARMED;
        endcase

        // Shared by a wrong EVAL verdict and a double press in ARMED.
        if (w_fail_take) begin
            w_fail_next = w_fail_inc;
            if (w_fail_inc == MAX_FAILS_W) begin
                w_timer_next = TIMER_LOAD;
                w_state_next = LOCKOUT;
            end else begin
                w_state_next = ARMED;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ARMED;
            r_expected   <= 2'd0;
            r_timer      <= '0;
            r_fail_count <= 2'd0;
            r_key1_pulse <= 1'b0;
            r_key2_pulse <= 1'b0;
            r_fsm_reset  <= 1'b0;
            r_alarm      <= 1'b0;
            r_unlocked   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_expected   <= w_expected_next;
            r_timer      <= w_timer_next;
            r_fail_count <= w_fail_next;
            r_key1_pulse <= w_key1_next;
            r_key2_pulse <= w_key2_next;
            r_fsm_reset  <= (w_state_next == LOCKOUT) || w_relock_pulse;
            r_alarm      <= (w_state_next == LOCKOUT);
            r_unlocked   <= (w_state_next == UNLOCKED);
        end
    end

    assign Key1Pulse = r_key1_pulse;
    assign Key2Pulse = r_key2_pulse;
    assign FsmReset  = r_fsm_reset;
    assign Alarm     = r_alarm;
    assign Unlocked  = r_unlocked;
    assign FailCount = r_fail_count;
    assign state     = r_state;

endmodule
